// File: rtl/vga_plot_arbiter_pkg.sv
// Shared types and screen constants for the VGA plot arbiter slice.
package vga_plot_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOR_W  = 3;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

  function automatic logic in_screen(input pixel_t p);
    return (p.x < X_W'(SCREEN_W)) && (p.y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Bundles the two drawer write ports, the VGA write port and status flags.
interface vga_plot_arbiter_if;
  import vga_plot_pkg::*;

  logic               req0_plot;
  logic [X_W-1:0]     req0_x;
  logic [Y_W-1:0]     req0_y;
  logic [COLOR_W-1:0] req0_color;
  logic               req0_ready;

  logic               req1_plot;
  logic [X_W-1:0]     req1_x;
  logic [Y_W-1:0]     req1_y;
  logic [COLOR_W-1:0] req1_color;
  logic               req1_ready;

  logic               clear_overflow;

  logic               vga_plot;
  logic [X_W-1:0]     vga_x;
  logic [Y_W-1:0]     vga_y;
  logic [COLOR_W-1:0] vga_color;
  logic               overflow;
  logic               busy;

  // Drawer / upstream side
  modport master (
    output req0_plot, req0_x, req0_y, req0_color,
    output req1_plot, req1_x, req1_y, req1_color,
    output clear_overflow,
    input  req0_ready, req1_ready,
    input  vga_plot, vga_x, vga_y, vga_color, overflow, busy
  );

  // Arbiter side
  modport slave (
    input  req0_plot, req0_x, req0_y, req0_color,
    input  req1_plot, req1_x, req1_y, req1_color,
    input  clear_overflow,
    output req0_ready, req1_ready,
    output vga_plot, vga_x, vga_y, vga_color, overflow, busy
  );

endinterface

// File: rtl/vga_plot_arbiter_plot_fifo.sv
// First-word-fall-through pixel FIFO; a full FIFO still accepts a push when
// it is popped in the same cycle.
module plot_fifo
  import vga_plot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push_i,
  input  pixel_t data_i,
  input  logic   pop_i,
  output pixel_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pixel_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               pop_ok;
  logic               push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin merge of sprite and background pixel streams onto one VGA port.
// Optional PLOT_CLIP_EN discards off-screen pushes before they reach the FIFOs.
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clock,
  input logic               reset,
  vga_plot_arbiter_if.slave bus
);

  pixel_t pix0, pix1;
  pixel_t head0, head1;
  logic   push0, push1;
  logic   pop0, pop1;
  logic   full0, full1;
  logic   empty0, empty1;
  logic   drop;

  logic   vga_plot_q;
  pixel_t vga_pix_q;
  logic   overflow_q;
  grant_e last_grant_q;

  assign pix0 = '{x: bus.req0_x, y: bus.req0_y, color: bus.req0_color};
  assign pix1 = '{x: bus.req1_x, y: bus.req1_y, color: bus.req1_color};

`ifdef PLOT_CLIP_EN
  assign push0 = bus.req0_plot && in_screen(pix0);
  assign push1 = bus.req1_plot && in_screen(pix1);
`else
  assign push0 = bus.req0_plot;
  assign push1 = bus.req1_plot;
`endif

  plot_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clock  (clock),
    .reset  (reset),
    .push_i (push0),
    .data_i (pix0),
    .pop_i  (pop0),
    .head_o (head0),
    .full_o (full0),
    .empty_o(empty0)
  );

  plot_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clock  (clock),
    .reset  (reset),
    .push_i (push1),
    .data_i (pix1),
    .pop_i  (pop1),
    .head_o (head1),
    .full_o (full1),
    .empty_o(empty1)
  );

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (!empty0 && (empty1 || last_grant_q == GRANT_REQ1)) begin
      pop0 = 1'b1;
    end else if (!empty1) begin
      pop1 = 1'b1;
    end
  end

  assign drop = (push0 && full0 && !pop0) || (push1 && full1 && !pop1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_plot_q   <= 1'b0;
      vga_pix_q    <= '0;
      overflow_q   <= 1'b0;
      last_grant_q <= GRANT_REQ1;
    end else begin
      vga_plot_q <= pop0 || pop1;
      if (pop0) begin
        vga_pix_q    <= head0;
        last_grant_q <= GRANT_REQ0;
      end else if (pop1) begin
        vga_pix_q    <= head1;
        last_grant_q <= GRANT_REQ1;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clear_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.vga_plot   = vga_plot_q;
  assign bus.vga_x      = vga_pix_q.x;
  assign bus.vga_y      = vga_pix_q.y;
  assign bus.vga_color  = vga_pix_q.color;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = !empty0 || !empty1 || vga_plot_q;
  assign bus.req0_ready = !full0;
  assign bus.req1_ready = !full1;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomized and directed bench for vga_plot_arbiter against a queue-based
// model of the two pixel streams (honours PLOT_CLIP_EN when defined).
module tb_vga_plot_arbiter;
  import vga_plot_pkg::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   totalChecks = 0;
  int   badChecks = 0;

  always #5 clock = ~clock;

  vga_plot_arbiter_if bus ();

  vga_plot_arbiter #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: two pixel queues, the last winner, sticky overflow.
  pixel_t q0[$];
  pixel_t q1[$];
  int     lastWinner = 1;
  bit     expOverflow = 1'b0;
  bit     expPlot = 1'b0;
  pixel_t expPix = '0;

  function automatic pixel_t mkPix(input int x, input int y, input int c);
    pixel_t p;
    p.x     = X_W'(x);
    p.y     = Y_W'(y);
    p.color = COLOR_W'(c);
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit accepts(input bit plot, input pixel_t p);
`ifdef PLOT_CLIP_EN
    return plot && (int'(p.x) < SCREEN_W) && (int'(p.y) < SCREEN_H);
`else
    return plot;
`endif
  endfunction

  task automatic modelEdge(input bit p0, input pixel_t d0, input bit p1, input pixel_t d1, input bit clr);
    int winner;
    bit lost;
    winner = -1;
    lost   = 1'b0;
    if (q0.size() > 0 && q1.size() > 0) winner = (lastWinner == 0) ? 1 : 0;
    else if (q0.size() > 0) winner = 0;
    else if (q1.size() > 0) winner = 1;
    expPlot = (winner >= 0);
    if (winner == 0) begin
      expPix = q0.pop_front();
      lastWinner = 0;
    end else if (winner == 1) begin
      expPix = q1.pop_front();
      lastWinner = 1;
    end
    if (accepts(p0, d0)) begin
      if (q0.size() < DEPTH) q0.push_back(d0);
      else lost = 1'b1;
    end
    if (accepts(p1, d1)) begin
      if (q1.size() < DEPTH) q1.push_back(d1);
      else lost = 1'b1;
    end
    if (lost) expOverflow = 1'b1;
    else if (clr) expOverflow = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".plot"},  32'(bus.vga_plot),   32'(expPlot));
    checkOutput({tag, ".x"},     32'(bus.vga_x),      32'(expPix.x));
    checkOutput({tag, ".y"},     32'(bus.vga_y),      32'(expPix.y));
    checkOutput({tag, ".color"}, 32'(bus.vga_color),  32'(expPix.color));
    checkOutput({tag, ".ovf"},   32'(bus.overflow),   32'(expOverflow));
    checkOutput({tag, ".busy"},  32'(bus.busy),
                32'(q0.size() > 0 || q1.size() > 0 || expPlot));
    checkOutput({tag, ".rdy0"},  32'(bus.req0_ready), 32'(q0.size() < DEPTH));
    checkOutput({tag, ".rdy1"},  32'(bus.req1_ready), 32'(q1.size() < DEPTH));
  endtask

  task automatic applyStimulus(input string tag, input bit p0, input pixel_t d0,
                               input bit p1, input pixel_t d1, input bit clr);
    bus.req0_plot      = p0;
    bus.req0_x         = d0.x;
    bus.req0_y         = d0.y;
    bus.req0_color     = d0.color;
    bus.req1_plot      = p1;
    bus.req1_x         = d1.x;
    bus.req1_y         = d1.y;
    bus.req1_color     = d1.color;
    bus.clear_overflow = clr;
    @(posedge clock);
    modelEdge(p0, d0, p1, d1, clr);
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag, input int n, input bit clr);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, '0, 1'b0, '0, clr);
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    lastWinner  = 1;
    expOverflow = 1'b0;
    expPlot     = 1'b0;
    expPix      = '0;
  endtask

  task automatic asyncReset(input string tag);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkAll(tag);
    bus.req0_plot      = 1'b0;
    bus.req1_plot      = 1'b0;
    bus.clear_overflow = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.req0_plot = 1'b0; bus.req0_x = '0; bus.req0_y = '0; bus.req0_color = '0;
    bus.req1_plot = 1'b0; bus.req1_x = '0; bus.req1_y = '0; bus.req1_color = '0;
    bus.clear_overflow = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] single push latency");
    applyStimulus("single", 1'b1, mkPix(5, 16, 4), 1'b0, '0, 1'b0);
    idle("single_drain", 3, 1'b0);

    $display("[TB] dual 8-cycle burst");
    for (int i = 0; i < 8; i++)
      applyStimulus("burst", 1'b1, mkPix(i, 10, 1), 1'b1, mkPix(100 + i, 20, 2), 1'b0);
    idle("burst_drain", 12, 1'b0);

    $display("[TB] backlog then req1 alone");
    for (int i = 0; i < 4; i++)
      applyStimulus("backlog", 1'b1, mkPix(i, 1, 3), 1'b1, mkPix(200 + i, 2, 5), 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus("req1_only", 1'b0, '0, 1'b1, mkPix(210 + i, 3, 6), 1'b0);
    idle("backlog_drain", 12, 1'b0);

    $display("[TB] overflow set and clear");
    for (int i = 0; i < 10; i++)
      applyStimulus("ovf_fill", 1'b1, mkPix(i, 4, 1), 1'b1, mkPix(50 + i, 5, 2), 1'b0);
    idle("ovf_drain", 12, 1'b0);
    applyStimulus("ovf_clear", 1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++)
      applyStimulus("ovf_refill", 1'b1, mkPix(i, 6, 7), 1'b1, mkPix(60 + i, 7, 0), 1'b0);
    applyStimulus("ovf_setwins", 1'b1, mkPix(30, 8, 1), 1'b1, mkPix(70, 9, 2), 1'b1);
    idle("ovf_drain2", 12, 1'b1);

    $display("[TB] async reset mid-burst");
    for (int i = 0; i < 3; i++)
      applyStimulus("pre_reset", 1'b1, mkPix(i, 11, 3), 1'b1, mkPix(80 + i, 12, 4), 1'b0);
    asyncReset("mid_reset");
    idle("post_reset", 4, 1'b0);

    $display("[TB] off-screen pixels");
    applyStimulus("clip_x", 1'b1, mkPix(320, 10, 2), 1'b0, '0, 1'b0);
    applyStimulus("clip_y", 1'b1, mkPix(10, 240, 5), 1'b0, '0, 1'b0);
    idle("clip_drain", 4, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      bit p0, p1, clr;
      p0  = ($urandom_range(0, 9) < 6);
      p1  = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 9) == 0);
      applyStimulus("rand",
                    p0, mkPix($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 7)),
                    p1, mkPix($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 7)),
                    clr);
      if (i == 200) begin
        asyncReset("rand_reset");
      end
    end
    idle("final_drain", 12, 1'b1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
